// File: rtl/fsb_pkt_fifo.sv
// Elastic FSB packet buffer: (DEPTH_P-1)-entry RAM plus one output register, registered ready/count/almost-full.
// Optional statistics counters are enabled by defining FSB_PKT_FIFO_STATS_EN.
module fsb_pkt_fifo #(
    parameter int WIDTH_P     = 80,
    parameter int DEPTH_P     = 16,
    parameter int AF_THRESH_P = 12
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         in_v_i,
    input  logic [WIDTH_P-1:0]           in_data_i,
    output logic                         in_ready_o,
    output logic                         out_v_o,
    output logic [WIDTH_P-1:0]           out_data_o,
    input  logic                         out_ready_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH_P+1)-1:0] count_o,
    output logic                         almost_full_o
`ifdef FSB_PKT_FIFO_STATS_EN
    ,
    output logic [31:0]                  push_cnt_o,
    output logic [31:0]                  pop_cnt_o,
    output logic [31:0]                  stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH_P + 1);
    localparam int RAM_D = DEPTH_P - 1;
    localparam int PTR_W = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAM_D - 1);

    logic [WIDTH_P-1:0] mem [RAM_D];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   ram_cnt;
    logic [CNT_W-1:0]   count_r;
    logic               out_v_r;
    logic [WIDTH_P-1:0] out_data_r;
    logic               in_ready_r;
    logic               af_r;

    logic               push, pop, load_out, ram_rd, bypass, ram_wr;
    logic [CNT_W-1:0]   count_next;

    // Valid/ready: a beat transfers on a cycle where valid and ready are both
    // high at the clock edge; valid never waits on ready, and a presented beat
    // holds its data until it transfers.
    always_comb begin
        push       = in_v_i & in_ready_r;
        pop        = out_v_r & out_ready_i;
        load_out   = ~out_v_r | pop;
        ram_rd     = load_out & (ram_cnt != '0);
        bypass     = load_out & (ram_cnt == '0) & push;
        ram_wr     = push & ~bypass;
        count_next = count_r + CNT_W'(push) - CNT_W'(pop);
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Storage array carries no reset; only the pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (ram_wr && !flush_i)
            mem[wr_ptr] <= in_data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            count_r    <= '0;
            out_v_r    <= 1'b0;
            out_data_r <= '0;
            in_ready_r <= 1'b0;
            af_r       <= 1'b0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            count_r    <= '0;
            out_v_r    <= 1'b0;
            out_data_r <= '0;
            in_ready_r <= 1'b0;
            af_r       <= 1'b0;
        end else begin
            if (ram_wr)
                wr_ptr <= ptr_inc(wr_ptr);
            if (ram_rd)
                rd_ptr <= ptr_inc(rd_ptr);
            ram_cnt <= ram_cnt + CNT_W'(ram_wr) - CNT_W'(ram_rd);
            // Output register refills in the pop cycle for full throughput;
            // with an empty RAM a push goes straight to it.
            if (load_out) begin
                if (ram_rd) begin
                    out_v_r    <= 1'b1;
                    out_data_r <= mem[rd_ptr];
                end else if (bypass) begin
                    out_v_r    <= 1'b1;
                    out_data_r <= in_data_i;
                end else begin
                    out_v_r    <= 1'b0;
                end
            end
            count_r    <= count_next;
            in_ready_r <= (count_next < CNT_W'(DEPTH_P));
            af_r       <= (count_next >= CNT_W'(AF_THRESH_P));
        end
    end

    assign in_ready_o    = in_ready_r;
    assign out_v_o       = out_v_r;
    assign out_data_o    = out_data_r;
    assign count_o       = count_r;
    assign almost_full_o = af_r;

`ifdef FSB_PKT_FIFO_STATS_EN
    logic [31:0] push_cnt_r, pop_cnt_r, stall_cnt_r;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            push_cnt_r  <= '0;
            pop_cnt_r   <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (push)
                push_cnt_r <= push_cnt_r + 32'd1;
            if (pop)
                pop_cnt_r <= pop_cnt_r + 32'd1;
            if (in_v_i && !in_ready_r)
                stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign push_cnt_o  = push_cnt_r;
    assign pop_cnt_o   = pop_cnt_r;
    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fsb_pkt_fifo.sv
// Directed self-checking bench for fsb_pkt_fifo; covers statistics when FSB_PKT_FIFO_STATS_EN is defined.
module tb_fsb_pkt_fifo;

    localparam int W = 80;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          in_v_i;
    logic [W-1:0]  in_data_i;
    logic          in_ready_o;
    logic          out_v_o;
    logic [W-1:0]  out_data_o;
    logic          out_ready_i;
    logic          flush_i;
    logic [4:0]    count_o;
    logic          almost_full_o;
`ifdef FSB_PKT_FIFO_STATS_EN
    logic [31:0]   push_cnt_o, pop_cnt_o, stall_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    fsb_pkt_fifo #(.WIDTH_P(80), .DEPTH_P(16), .AF_THRESH_P(12)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .in_v_i        (in_v_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .out_v_o       (out_v_o),
        .out_data_o    (out_data_o),
        .out_ready_i   (out_ready_i),
        .flush_i       (flush_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o)
`ifdef FSB_PKT_FIFO_STATS_EN
        ,
        .push_cnt_o    (push_cnt_o),
        .pop_cnt_o     (pop_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a packet valid until it is accepted (bounded).
    task automatic push_pkt(input logic [W-1:0] d);
        logic rdy;
        bit   done;
        done      = 0;
        in_v_i    = 1'b1;
        in_data_i = d;
        for (int k = 0; k < 40 && !done; k++) begin
            rdy = in_ready_o;
            tick();
            if (rdy) done = 1;
        end
        in_v_i = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    initial begin
        logic         rdy, v;
        logic [W-1:0] d, e, nxt;
        int           acc, cyc;

        reset_i     = 1'b1;
        in_v_i      = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_v", out_v_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_count", count_o, 0);
        check("rst_af", almost_full_o, 0);
        reset_i = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready_o, 1);

        // 1: single packet, 1-cycle latency
        out_ready_i = 1'b1;
        push_pkt(80'h1_0000_0000_0000_0001);
        check("t1_out_v", out_v_o, 1);
        check("t1_out_data", out_data_o, 80'h1_0000_0000_0000_0001);
        check("t1_count1", count_o, 1);
        tick();
        check("t1_out_v_after", out_v_o, 0);
        check("t1_count0", count_o, 0);

        // 2: fill to 16 with valid held
        out_ready_i = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 16 && cyc < 40) begin
            in_v_i    = 1'b1;
            in_data_i = W'(acc);
            rdy       = in_ready_o;
            tick();
            cyc++;
            if (rdy) begin
                exp_q.push_back(W'(acc));
                acc++;
            end
            check("t2_count", count_o, W'(acc));
            check("t2_af", almost_full_o, W'(acc >= 12));
        end
        check("t2_pushes", W'(acc), 16);
        check("t2_in_ready_full", in_ready_o, 0);
        in_data_i = 80'h999;
        repeat (3) begin
            tick();
            check("t2_hold_count", count_o, 16);
            check("t2_hold_ready", in_ready_o, 0);
        end

        // 3: drain from full at 1 pkt/cycle while still pushing
        out_ready_i = 1'b1;
        nxt = 80'd100;
        for (int k = 0; k < 24; k++) begin
            in_v_i    = 1'b1;
            in_data_i = nxt;
            rdy = in_ready_o;
            v   = out_v_o;
            d   = out_data_o;
            tick();
            check("t3_out_v", v, 1);
            if (v) begin
                if (exp_q.size() == 0) check("t3_extra_pop", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("t3_data", d, e);
                end
            end
            if (rdy) begin
                exp_q.push_back(nxt);
                nxt = nxt + 1;
            end
        end
        check("t3_count_steady", count_o, 15);
        in_v_i = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 60) begin
            v = out_v_o;
            d = out_data_o;
            tick();
            cyc++;
            if (v) begin
                e = exp_q.pop_front();
                check("t3_drain_data", d, e);
            end
        end
        check("t3_drain_left", W'(exp_q.size()), 0);
        check("t3_drain_count", count_o, 0);
        check("t3_drain_out_v", out_v_o, 0);

        // 4: flush with a concurrent push attempt
        out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) push_pkt(W'(8'h50 + k));
        check("t4_count5", count_o, 5);
        flush_i   = 1'b1;
        in_v_i    = 1'b1;
        in_data_i = 80'hFF;
        tick();
        flush_i = 1'b0;
        in_v_i  = 1'b0;
        check("t4_flush_count", count_o, 0);
        check("t4_flush_out_v", out_v_o, 0);
        check("t4_flush_ready", in_ready_o, 0);
        tick();
        check("t4_ready_back", in_ready_o, 1);
        check("t4_still_empty", count_o, 0);
        out_ready_i = 1'b1;
        push_pkt(80'hAA);
        check("t4_first_v", out_v_o, 1);
        check("t4_first_data", out_data_o, 80'hAA);
        tick();
        check("t4_empty_again", count_o, 0);

        // 5: async reset mid-burst
        out_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) push_pkt(W'(8'h70 + k));
        check("t5_count7", count_o, 7);
        check("t5_data_head", out_data_o, 80'h70);
        reset_i = 1'b1;
        #1;
        check("t5_rst_out_v", out_v_o, 0);
        check("t5_rst_count", count_o, 0);
        check("t5_rst_ready", in_ready_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        tick();
        check("t5_ready_after", in_ready_o, 1);
        check("t5_out_v_after", out_v_o, 0);

`ifdef FSB_PKT_FIFO_STATS_EN
        // 6: 20 cycles of valid, no pops
        in_v_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data_i = W'(k);
            tick();
        end
        in_v_i = 1'b0;
        check("t6_push_cnt", W'(push_cnt_o), 16);
        check("t6_pop_cnt", W'(pop_cnt_o), 0);
        check("t6_stall_ge4", W'(stall_cnt_o >= 32'd4), 1);
        check("t6_count", count_o, 16);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
